// File: rtl/stim_pkg.sv
// Shared types, default sizes and lane helper for the stimulus sequencer.
package stim_pkg;

    localparam int unsigned STIM_N     = 8;
    localparam int unsigned STIM_W     = 16;
    localparam int unsigned STIM_DEPTH = 4;
    localparam int unsigned STIM_GAP_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } stim_state_e;

    // Pull one W-bit lane out of a flattened vector; lane 0 sits in the LSBs.
    function automatic logic [STIM_W-1:0] stim_lane(
        input logic [STIM_N*STIM_W-1:0] flat,
        input int unsigned              lane
    );
        return flat[lane*STIM_W +: STIM_W];
    endfunction

endpackage

// File: rtl/stim_pattern_mem.sv
// Pattern storage: DEPTH entries, one synchronous write port, one async read port.
module stim_pattern_mem
    import stim_pkg::*;
#(
    parameter int unsigned DEPTH = STIM_DEPTH,
    parameter int unsigned DW    = STIM_N * STIM_W,
    parameter int unsigned AW    = $clog2(STIM_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Entry write; reset clears the whole pattern table.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stim_sequencer.sv
// Plays stored stimulus vectors to a downstream block with valid/ready, idle gaps,
// optional looping and early stop. All outputs are registered.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int unsigned N     = STIM_N,
    parameter int unsigned W     = STIM_W,
    parameter int unsigned DEPTH = STIM_DEPTH,
    parameter int unsigned GAP_W = STIM_GAP_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [N*W-1:0]             wr_data,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       mode_loop,
    input  logic [$clog2(DEPTH+1)-1:0] num_vec,
    input  logic [GAP_W-1:0]           gap,
    input  logic                       ready_in,
    output logic                       en,
    output logic                       valid_in,
    output logic [N*W-1:0]             in_x_flat,
    output logic [$clog2(DEPTH)-1:0]   vec_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = N * W;

    stim_state_e r_state, w_state_d;

    logic [AW-1:0]    r_ptr, w_ptr_d;
    logic [CW-1:0]    r_num, w_num_d;
    logic [GAP_W-1:0] r_gap, w_gap_d;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_d;
    logic             r_loop, w_loop_d;
    logic             r_stop_pend, w_stop_pend_d;

    logic             w_last;
    logic             w_stop;
    logic [DW-1:0]    w_rd_data;

    logic             w_en_d, w_valid_d, w_done_d;
    logic [DW-1:0]    w_data_d;
    logic [AW-1:0]    w_idx_d;

    logic             r_en, r_valid, r_busy, r_done;
    logic [DW-1:0]    r_data;
    logic [AW-1:0]    r_idx;

    // Read address is the next pointer so registered data lines up with vec_idx.
    stim_pattern_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (wr_en && (r_state == StIdle)),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (w_ptr_d),
        .o_rdata (w_rd_data)
    );

    assign w_last = (CW'(r_ptr) == (r_num - CW'(1)));
    assign w_stop = stop || r_stop_pend;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state plus run context (pointer, captured config, gap counter, pending stop).
    always_comb begin
        w_state_d     = r_state;
        w_ptr_d       = r_ptr;
        w_num_d       = r_num;
        w_gap_d       = r_gap;
        w_loop_d      = r_loop;
        w_gap_cnt_d   = r_gap_cnt;
        w_stop_pend_d = r_stop_pend;
        unique case (r_state)
            StIdle: begin
                // A stop in the same cycle cancels the start.
                if (start && !stop && (num_vec != '0)) begin
                    w_state_d     = StSend;
                    w_num_d       = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
                    w_gap_d       = gap;
                    w_loop_d      = mode_loop;
                    w_ptr_d       = '0;
                    w_stop_pend_d = 1'b0;
                end
            end
            StSend: begin
                // Valid is never withdrawn, so a stop waits here for the accept.
                if (stop) begin
                    w_stop_pend_d = 1'b1;
                end
                if (ready_in) begin
                    w_ptr_d = w_last ? '0 : r_ptr + AW'(1);
                    if ((w_last && !r_loop) || w_stop) begin
                        w_state_d     = StDone;
                        w_stop_pend_d = 1'b0;
                    end else if (r_gap != '0) begin
                        w_state_d   = StGap;
                        w_gap_cnt_d = r_gap;
                    end
                end
            end
            StGap: begin
                if (w_stop) begin
                    w_state_d     = StDone;
                    w_stop_pend_d = 1'b0;
                end else if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_d = StSend;
                end else begin
                    w_gap_cnt_d = r_gap_cnt - GAP_W'(1);
                end
            end
            StDone: begin
                w_state_d     = StIdle;
                w_stop_pend_d = 1'b0;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output values derived from the upcoming state; data and index are zero unless valid.
    always_comb begin
        w_en_d    = (w_state_d == StSend) || (w_state_d == StGap);
        w_valid_d = (w_state_d == StSend);
        w_done_d  = (w_state_d == StDone);
        w_data_d  = w_valid_d ? w_rd_data : '0;
        w_idx_d   = w_valid_d ? w_ptr_d : '0;
    end

    // Run context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_num       <= '0;
            r_gap       <= '0;
            r_loop      <= 1'b0;
            r_gap_cnt   <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_d;
            r_num       <= w_num_d;
            r_gap       <= w_gap_d;
            r_loop      <= w_loop_d;
            r_gap_cnt   <= w_gap_cnt_d;
            r_stop_pend <= w_stop_pend_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            r_en    <= w_en_d;
            r_valid <= w_valid_d;
            r_busy  <= w_en_d;
            r_done  <= w_done_d;
            r_data  <= w_data_d;
            r_idx   <= w_idx_d;
        end
    end

    assign en        = r_en;
    assign valid_in  = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign in_x_flat = r_data;
    assign vec_idx   = r_idx;

endmodule

// File: tb/tb_stim_sequencer.sv
// Randomised bench for stim_sequencer: a per-run schedule model predicts every output cycle.
module tb_stim_sequencer;
    import stim_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned DW    = N * W;
    localparam int          MAXL  = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic              stop;
    logic              mode_loop;
    logic [CW-1:0]     num_vec;
    logic [GAP_W-1:0]  gap;
    logic              ready_in;
    logic              en;
    logic              valid_in;
    logic [DW-1:0]     in_x_flat;
    logic [AW-1:0]     vec_idx;
    logic              busy;
    logic              done;

    stim_sequencer #(
        .N     (N),
        .W     (W),
        .DEPTH (DEPTH),
        .GAP_W (GAP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .mode_loop (mode_loop),
        .num_vec   (num_vec),
        .gap       (gap),
        .ready_in  (ready_in),
        .en        (en),
        .valid_in  (valid_in),
        .in_x_flat (in_x_flat),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: pattern table and the expected per-cycle outputs of one run.
    logic [DW-1:0] mdl_mem [DEPTH];
    bit            e_en    [MAXL];
    bit            e_valid [MAXL];
    bit            e_done  [MAXL];
    int            e_idx   [MAXL];
    logic [DW-1:0] e_data  [MAXL];
    bit            rdy     [MAXL];
    int            sched_len;
    int            cyc;
    bit            chk_on = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the schedule while a run is active.
    always @(negedge clk) begin
        if (chk_on) begin
            check("en", DW'(en), DW'(e_en[cyc]));
            check("busy", DW'(busy), DW'(e_en[cyc]));
            check("valid_in", DW'(valid_in), DW'(e_valid[cyc]));
            check("done", DW'(done), DW'(e_done[cyc]));
            check("vec_idx", DW'(vec_idx), DW'(e_idx[cyc]));
            check("in_x_flat", in_x_flat, e_data[cyc]);
        end
    end

    task automatic rdy_all_high();
        for (int i = 0; i < MAXL; i++) rdy[i] = 1'b1;
    endtask

    task automatic rdy_random();
        for (int i = 0; i < MAXL; i++) rdy[i] = (i < 100) ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Walk the run vector by vector: cycle 0 is the start cycle, the run
    // ends with one done cycle and one idle cycle.
    task automatic build_sched(input int nv, input int g_len, input bit loop, input int stop_at,
                               input bit ignored);
        int n, ptr, c;
        bit stopped, fin, acc, last;
        for (int i = 0; i < MAXL; i++) begin
            e_en[i] = 0; e_valid[i] = 0; e_done[i] = 0; e_idx[i] = 0; e_data[i] = '0;
        end
        if (ignored) begin
            sched_len = 4;
            return;
        end
        n = (nv > int'(DEPTH)) ? int'(DEPTH) : nv;
        ptr = 0; c = 1; stopped = 0; fin = 0;
        while (!fin && c < MAXL - 40) begin
            acc = 0;
            while (!acc) begin
                e_en[c] = 1; e_valid[c] = 1; e_idx[c] = ptr; e_data[c] = mdl_mem[ptr];
                if (c == stop_at) stopped = 1;
                acc = rdy[c];
                c++;
            end
            last = (ptr == n - 1);
            ptr = last ? 0 : ptr + 1;
            if ((last && !loop) || stopped) begin
                fin = 1;
            end else begin
                for (int k = 0; k < g_len && !fin; k++) begin
                    e_en[c] = 1;
                    if (c == stop_at) fin = 1;
                    c++;
                end
            end
        end
        e_done[c] = 1;
        sched_len = c + 2;
    endtask

    task automatic run(input int nv, input int g_len, input bit loop, input int stop_at,
                       input bit stop_with_start, input bit noise);
        bit ign;
        ign = (nv == 0) || stop_with_start;
        build_sched(nv, g_len, loop, stop_at, ign);
        @(posedge clk); #1;
        start = 1'b1; num_vec = CW'(nv); gap = GAP_W'(g_len); mode_loop = loop;
        stop = stop_with_start; ready_in = rdy[0]; wr_en = 1'b0;
        cyc = 0; chk_on = 1'b1;
        for (int c = 1; c < sched_len; c++) begin
            @(posedge clk); #1;
            cyc = c;
            stop = (c == stop_at);
            ready_in = rdy[c];
            if (noise && !ign && c <= sched_len - 2) begin
                // Writes and starts outside IDLE, and config changes mid-run, must all be inert.
                start = 1'($urandom_range(0, 1));
                wr_en = 1'($urandom_range(0, 1));
                wr_addr = AW'($urandom_range(0, DEPTH - 1));
                wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                num_vec = CW'($urandom_range(1, 7));
                gap = GAP_W'($urandom_range(0, 15));
                mode_loop = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk_on = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0; ready_in = 1'b0;
    endtask

    task automatic write_mem(input int addr, input logic [DW-1:0] data);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mdl_mem[addr] = data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, DW'(en), '0);
        check({tag, "_valid"}, DW'(valid_in), '0);
        check({tag, "_data"}, in_x_flat, '0);
        check({tag, "_idx"}, DW'(vec_idx), '0);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_done"}, DW'(done), '0);
    endtask

    initial begin
        logic [DW-1:0] p0, p1, p2;
        p0 = {N{16'hFFE5}};
        p1 = {N{16'h0FFF}};
        p2 = {N{16'h0028}};
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stop = 1'b0;
        mode_loop = 1'b0; num_vec = '0; gap = '0; ready_in = 1'b0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        write_mem(0, p0);
        write_mem(1, p1);
        write_mem(2, p2);
        write_mem(3, {N{16'h1234}});

        // Three back-to-back vectors, done one cycle after the last.
        rdy_all_high();
        run(3, 0, 0, -1, 0, 0);
        check("pin_b2b_idx2", DW'(e_idx[3]), DW'(2));
        check("pin_b2b_valid3", DW'(e_valid[3]), DW'(1));
        check("pin_b2b_done4", DW'(e_done[4]), DW'(1));
        check("pin_b2b_lane0", DW'(stim_lane(e_data[1], 0)), DW'(16'hFFE5));
        check("pin_b2b_lane7", DW'(stim_lane(e_data[2], N - 1)), DW'(16'h0FFF));

        // Backpressure on idx 1 for four cycles.
        rdy_all_high();
        for (int i = 2; i <= 5; i++) rdy[i] = 1'b0;
        run(3, 0, 0, -1, 0, 0);
        check("pin_bp_hold_first", e_data[2], p1);
        check("pin_bp_hold_last", e_data[6], p1);
        check("pin_bp_next_idx", DW'(e_idx[7]), DW'(2));
        check("pin_bp_done", DW'(e_done[8]), DW'(1));

        // Two-cycle gap between two vectors.
        rdy_all_high();
        run(2, 2, 0, -1, 0, 0);
        check("pin_gap_en", DW'(e_en[3]), DW'(1));
        check("pin_gap_idle", DW'(e_valid[3]), DW'(0));
        check("pin_gap_v1", DW'(e_valid[4]), DW'(1));
        check("pin_gap_done", DW'(e_done[5]), DW'(1));

        // Looping with stop on cycle 7.
        rdy_all_high();
        run(3, 0, 1, 7, 0, 0);
        check("pin_loop_idx4", DW'(e_idx[4]), DW'(0));
        check("pin_loop_idx7", DW'(e_idx[7]), DW'(0));
        check("pin_loop_done", DW'(e_done[8]), DW'(1));

        // num_vec == 0 is ignored; start+stop together is ignored; oversize is clamped.
        rdy_all_high();
        run(0, 0, 0, -1, 0, 0);
        run(3, 0, 0, -1, 1, 0);
        run(DEPTH + 3, 0, 0, -1, 0, 0);
        check("pin_clamp_idx", DW'(e_idx[4]), DW'(3));
        check("pin_clamp_done", DW'(e_done[5]), DW'(1));

        // Reset mid-SEND at idx 1: immediate zero outputs, no done, memory cleared.
        @(posedge clk); #1;
        start = 1'b1; num_vec = CW'(3); gap = '0; mode_loop = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        ready_in = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", DW'(valid_in), DW'(1));
        check("rst_pre_idx", DW'(vec_idx), DW'(1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", DW'(done), '0);
            check("rst_idle_en", DW'(en), '0);
        end
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
        rdy_all_high();
        run(3, 0, 0, -1, 0, 0);

        // Randomised runs with noise on every inert input.
        for (int r = 0; r < 40; r++) begin
            int nv, g, st;
            bit lp;
            if ($urandom_range(0, 1) == 1) begin
                write_mem($urandom_range(0, DEPTH - 1), {$urandom(), $urandom(), $urandom(), $urandom()});
            end
            nv = $urandom_range(0, 7);
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            lp = 1'($urandom_range(0, 1));
            if (lp) st = $urandom_range(1, 40);
            else st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
            rdy_random();
            run(nv, g, lp, st, ($urandom_range(0, 15) == 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter N, default 8, number of lanes per vector.
REQ-002 Parameter W, default 16, bits per lane (Q6.10 signed).
REQ-003 Parameter DEPTH, default 4, pattern entries stored; AW = $clog2(DEPTH), CW = $clog2(DEPTH+1).
REQ-004 Parameter GAP_W, default 4, width of idle-gap count.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  pattern write strobe.
REQ-008 wr_addr  input  AW  pattern write address.
REQ-009 wr_data  input  N*W  pattern write data.
REQ-010 start  input  1  begin a run (single-cycle pulse).
REQ-011 stop  input  1  request early termination.
REQ-012 mode_loop  input  1  1 = wrap and repeat, 0 = single pass.
REQ-013 num_vec  input  CW  vectors per pass.
REQ-014 gap  input  GAP_W  idle cycles inserted after each accepted vector.
REQ-015 ready_in  input  1  downstream accepts vector this cycle.
REQ-016 en  output  1  downstream enable, high while running.
REQ-017 valid_in  output  1  vector valid.
REQ-018 in_x_flat  output  N*W  vector data, lane 0 in bits [W-1:0].
REQ-019 vec_idx  output  AW  index of vector currently presented.
REQ-020 busy  output  1  high in SEND or GAP.
REQ-021 done  output  1  one-cycle pulse on run completion.

Function
REQ-022 States: IDLE, SEND, GAP, DONE; all outputs registered.
REQ-023 Writes take effect only in IDLE; wr_en in any other state is ignored.
REQ-024 start in IDLE with num_vec != 0 captures num_vec (clamped to DEPTH), gap, mode_loop, sets ptr = 0, enters SEND; valid_in = 1 on the next cycle.
REQ-025 start with num_vec == 0, or outside IDLE, is ignored.
REQ-026 SEND: valid_in = 1, en = 1, in_x_flat = mem[ptr], vec_idx = ptr; all held stable until ready_in = 1.
REQ-027 Accept (valid_in & ready_in): ptr = ptr+1, wrapping to 0 when ptr == captured num_vec-1.
REQ-028 After accept: captured gap > 0 enters GAP for exactly gap cycles (valid_in = 0, en = 1), then SEND; gap == 0 gives back-to-back vectors, one per cycle while ready_in = 1.
REQ-029 Pass end (accept at ptr == num_vec-1): mode_loop = 0 goes to DONE, skipping the gap; mode_loop = 1 wraps and continues.
REQ-030 stop in SEND takes effect at the next accept (valid never withdrawn unaccepted); stop in GAP goes to DONE immediately; stop is held internally until serviced.
REQ-031 DONE lasts one cycle: done = 1, en = 0, valid_in = 0, then IDLE.
REQ-032 IDLE: en = 0, valid_in = 0, in_x_flat = 0, busy = 0.
REQ-033 start and stop in the same IDLE cycle: start is ignored.

Reset
REQ-034 rst_n low, asynchronously: state = IDLE, ptr = 0, all outputs 0, pattern memory cleared to 0, pending stop cleared.
REQ-035 Reset mid-run aborts with no done pulse; release resumes in IDLE.

Structure
REQ-036 Package stim_pkg holds the state enum, default N/W/DEPTH/GAP_W constants and the lane-slice helper.
REQ-037 Pattern storage lives in sub-module stim_pattern_mem (DEPTH x N*W, one write port, one async read port).

Verification
REQ-038 Write mem[0..2] = {N{16'hFFE5}}, {N{16'h0FFF}}, {N{16'h0028}}; num_vec = 3, gap = 0, loop = 0, ready_in = 1, start -> valid_in on 3 consecutive cycles with idx 0,1,2, then done = 1 one cycle later.
REQ-039 Same patterns, ready_in low for 4 cycles on idx 1 -> in_x_flat = {N{16'h0FFF}} held 5 cycles, no index skipped.
REQ-040 gap = 2, num_vec = 2 -> sequence V0, 2 idle cycles with en = 1, V1, then done; 4 valid/idle cycles total before done.
REQ-041 loop = 1, num_vec = 3, stop on cycle 7 -> indices 0,1,2,0,1,2,0, then done after the pending accept.
REQ-042 rst_n low during SEND at idx 1 -> all outputs 0 immediately, no done pulse; memory reads 0 afterward.
REQ-043 num_vec = 0 start -> stays IDLE; num_vec = DEPTH+3 -> DEPTH vectors sent.
